rggen_trigger_scheduler: RTL and testbench
==========================================

Name: rggen_trigger_scheduler

Overview:
- Collects one-cycle trigger pulses from N trigger-type register bit fields.
- Holds each trigger as a pending request.
- Issues one request at a time to a single shared downstream engine, using round-robin order and a valid/ready start handshake, then waits for the engine's done pulse.
- Sits between the register block's trigger fields and the engine. It exposes pending, busy and sticky overflow/timeout status back to status bit fields.

Parameters:
- TRIGGERS, 4, number of trigger sources (>=1).
- TIMEOUT, 256, max cycles in WAIT_DONE before forced abort; 0 disables the watchdog.
- ID_WIDTH, (TRIGGERS>1)?$clog2(TRIGGERS):1, derived; width of the request id. Not overridden.
- CNT_WIDTH, (TIMEOUT>1)?$clog2(TIMEOUT+1):1, derived; watchdog counter width.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset; synchronous, active-high.
- i_trigger  input  TRIGGERS  one-cycle trigger pulses from trigger bit fields.
- i_enable  input  1  global issue enable.
- i_overflow_clear  input  TRIGGERS  per-source clear of sticky overflow.
- i_timeout_clear  input  1  clear of sticky timeout.
- o_start_valid  output  1  start request to the engine.
- o_start_id  output  ID_WIDTH  source id of the request.
- i_start_ready  input  1  engine accepts the start.
- i_done  input  1  engine completion pulse.
- o_pending  output  TRIGGERS  pending request flags.
- o_busy  output  1  high in ISSUE or WAIT_DONE.
- o_overflow  output  TRIGGERS  sticky: trigger arrived while already pending.
- o_timeout  output  1  sticky: watchdog expired.

Behaviour:
- Reset (i_rst high at a clock edge):
  - pending, overflow, timeout, o_start_valid, o_start_id, counter cleared to 0.
  - RR pointer cleared to 0.
  - State set to IDLE.
  - Reset mid-operation drops every request and any in-flight operation. No done is expected afterwards.
- Pending, per bit i:
  - set on i_trigger[i].
  - cleared the cycle after accept (o_start_valid & i_start_ready) with o_start_id==i.
  - Trigger in the same cycle as accept of the same i: the bit stays set (a new request).
- Overflow[i]:
  - set when i_trigger[i] and pending[i] and not (accept of i this cycle).
  - cleared by i_overflow_clear[i]. Set wins over clear in the same cycle.
- FSM states: IDLE, ISSUE, WAIT_DONE. All outputs are registered.
  - IDLE: if i_enable and any pending bit is set, grant via round-robin, starting at the pointer and searching upward with wrap. Next state ISSUE with o_start_valid=1 and o_start_id=grant.
  - ISSUE: o_start_valid and o_start_id held stable until i_start_ready.
    - On accept: o_start_valid=0, pointer=(id+1) mod TRIGGERS, counter=0, next state WAIT_DONE.
    - i_enable deasserting in ISSUE does not withdraw the request.
    - i_done in ISSUE is ignored.
  - WAIT_DONE: counter increments each cycle.
    - i_done: return to IDLE.
    - TIMEOUT!=0 and counter reaches TIMEOUT-1 without done: set o_timeout, return to IDLE.
    - i_done and expiry in the same cycle: done wins, no timeout.
  - i_done in IDLE is ignored.
- Latency:
  - trigger at cycle t gives o_pending at t+1.
  - o_start_valid at t+2 if idle and enabled.
  - The earliest next issue is 1 cycle after the done cycle: IDLE for one cycle, then ISSUE.
- Timeout sticky: cleared by i_timeout_clear. Set wins over clear.
- o_busy = (state != IDLE).
- TRIGGERS==1: o_start_id is constant 0 and the pointer is unused.

Decomposition:
- Package rggen_trigger_scheduler_pkg: state enum typedef (IDLE/ISSUE/WAIT_DONE) and a helper function for the ID_WIDTH computation.
- One sub-module, rggen_rr_arbiter: combinational round-robin grant over a TRIGGERS-bit request vector with a pointer input. Outputs are a grant index and a grant-valid flag.

Test Plan:
- Single trigger: TRIGGERS=4, pulse i_trigger=4'b0100 at t, i_start_ready=1 -> o_pending[2]=1 at t+1, o_start_valid=1 and o_start_id=2 at t+2, o_pending=0 at t+3; i_done 5 cycles later -> o_busy=0 the next cycle.
- Round-robin: i_trigger=4'b1111 in one cycle, engine done after 2 cycles each -> issue order 0,1,2,3. Then trigger 4'b1001 -> order 0,3.
- Backpressure and overflow: hold i_start_ready=0 for 10 cycles with id 1 issued, pulse i_trigger[1] twice -> o_start_valid/o_start_id stable; first pulse leaves pending[1]=1 and overflow 0; second pulse sets o_overflow[1]; assert i_overflow_clear[1] alone -> overflow 0.
- Trigger at accept: i_trigger[0] in the same cycle as accept of id 0 -> o_pending[0] stays 1 with no overflow; id 0 reissued after done.
- Timeout: TIMEOUT=8, no i_done -> o_timeout=1 after 8 WAIT_DONE cycles and state IDLE. Done on exactly the 8th cycle -> o_timeout stays 0.
- Reset and enable: i_enable=0 with pending=4'b0011 -> no start. Assert i_rst mid WAIT_DONE -> every output 0 next cycle and late i_done ignored.

Source files
------------

// File: rtl/rggen_trigger_scheduler_pkg.sv
// Shared types and helpers for the trigger scheduler: FSM state encoding and
// the request-id width derivation.
package rggen_trigger_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  function automatic int calc_id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rggen_rr_arbiter.sv
// Combinational round-robin grant: searches the request vector upward from
// the pointer with wrap-around and reports the first requester found.
module rggen_rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [IDW-1:0] o_grant,
  output logic           o_grant_valid
);

  int idx;

  // Scan offsets from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    o_grant       = '0;
    o_grant_valid = 1'b0;
    idx           = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(i_ptr) + k) % N;
      if (i_req[idx]) begin
        o_grant       = IDW'(idx);
        o_grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rggen_trigger_scheduler.sv
// Collects trigger pulses as pending requests and hands them one at a time to
// a shared engine (round-robin, valid/ready start, done pulse, watchdog).
module rggen_trigger_scheduler
  import rggen_trigger_scheduler_pkg::*;
#(
  parameter int TRIGGERS  = 4,
  parameter int TIMEOUT   = 256,
  parameter int ID_WIDTH  = calc_id_width(TRIGGERS),
  parameter int CNT_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [TRIGGERS-1:0] i_trigger,
  input  logic                i_enable,
  input  logic [TRIGGERS-1:0] i_overflow_clear,
  input  logic                i_timeout_clear,
  output logic                o_start_valid,
  output logic [ID_WIDTH-1:0] o_start_id,
  input  logic                i_start_ready,
  input  logic                i_done,
  output logic [TRIGGERS-1:0] o_pending,
  output logic                o_busy,
  output logic [TRIGGERS-1:0] o_overflow,
  output logic                o_timeout
);

  localparam logic [ID_WIDTH-1:0]  ID_LAST  = ID_WIDTH'(TRIGGERS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [TRIGGERS-1:0]   pending_q, pending_d;
  logic [TRIGGERS-1:0]   overflow_q, overflow_d;
  logic                  timeout_q, timeout_d;
  logic                  accept;
  logic [TRIGGERS-1:0]   accept_vec;
  logic [ID_WIDTH-1:0]   grant;
  logic                  grant_valid;

  assign accept = valid_q & i_start_ready;

  // A trigger coinciding with acceptance of the same source is a fresh request.
  for (genvar gi = 0; gi < TRIGGERS; gi++) begin : g_src
    assign accept_vec[gi] = accept && (id_q == ID_WIDTH'(gi));
    assign pending_d[gi]  = i_trigger[gi] | (pending_q[gi] & ~accept_vec[gi]);
    assign overflow_d[gi] = (i_trigger[gi] & pending_q[gi] & ~accept_vec[gi])
                          | (overflow_q[gi] & ~i_overflow_clear[gi]);
  end

  rggen_rr_arbiter #(
    .N   (TRIGGERS),
    .IDW (ID_WIDTH)
  ) u_arbiter (
    .i_req         (pending_q),
    .i_ptr         (ptr_q),
    .o_grant       (grant),
    .o_grant_valid (grant_valid)
  );

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q & ~i_timeout_clear;
    case (state_q)
      IDLE: begin
        if (i_enable && grant_valid) begin
          state_d = ISSUE;
          valid_d = 1'b1;
          id_d    = grant;
        end
      end
      ISSUE: begin
        if (i_start_ready) begin
          state_d = WAIT_DONE;
          valid_d = 1'b0;
          ptr_d   = (id_q == ID_LAST) ? '0 : id_q + 1'b1;
          cnt_d   = '0;
        end
      end
      WAIT_DONE: begin
        cnt_d = cnt_q + 1'b1;
        if (i_done) begin
          state_d = IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      id_q       <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      id_q       <= id_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_start_valid = valid_q;
  assign o_start_id    = id_q;
  assign o_pending     = pending_q;
  assign o_overflow    = overflow_q;
  assign o_timeout     = timeout_q;
  assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_rggen_trigger_scheduler.sv
// Directed bench for the trigger scheduler with TRIGGERS=4 and TIMEOUT=8.
module tb_rggen_trigger_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] trig;
  logic       en;
  logic [3:0] ovc;
  logic       toc;
  logic       rdy;
  logic       done;
  logic       valid;
  logic [1:0] id;
  logic [3:0] pending;
  logic       busy;
  logic [3:0] ovf;
  logic       tmo;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rggen_trigger_scheduler #(
    .TRIGGERS (4),
    .TIMEOUT  (8)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_trigger        (trig),
    .i_enable         (en),
    .i_overflow_clear (ovc),
    .i_timeout_clear  (toc),
    .o_start_valid    (valid),
    .o_start_id       (id),
    .i_start_ready    (rdy),
    .i_done           (done),
    .o_pending        (pending),
    .o_busy           (busy),
    .o_overflow       (ovf),
    .o_timeout        (tmo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(valid), 32'd1);
  endtask

  // Waits for a start, checks its id, accepts it and completes two cycles later.
  task automatic issue_one(input int exp_id, input string tag);
    wait_valid(tag);
    chk({tag, "_id"}, 32'(id), 32'(exp_id));
    rdy = 1'b1;
    tick();
    chk({tag, "_accepted"}, 32'(valid), 32'd0);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    $display("issue %s id=%0d", tag, exp_id);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; trig = '0; en = 1'b1; ovc = '0; toc = 1'b0; rdy = 1'b0; done = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_id", 32'(id), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_tmo", 32'(tmo), 32'd0);
    rst = 1'b0;

    // Single trigger latency
    rdy = 1'b1; trig = 4'b0100;
    tick();
    trig = '0;
    chk("t1_pending", 32'(pending), 32'h4);
    chk("t1_valid_early", 32'(valid), 32'd0);
    tick();
    chk("t1_valid", 32'(valid), 32'd1);
    chk("t1_id", 32'(id), 32'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_pending_clr", 32'(pending), 32'd0);
    chk("t1_valid_drop", 32'(valid), 32'd0);
    repeat (4) tick();
    chk("t1_wait_busy", 32'(busy), 32'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t1_done_idle", 32'(busy), 32'd0);
    $display("single trigger done");

    // Round-robin order
    do_reset();
    trig = 4'b1111;
    tick();
    trig = '0;
    chk("rr_pending", 32'(pending), 32'hF);
    issue_one(0, "rr0");
    issue_one(1, "rr1");
    issue_one(2, "rr2");
    issue_one(3, "rr3");
    chk("rr_pending_empty", 32'(pending), 32'd0);
    trig = 4'b1001;
    tick();
    trig = '0;
    issue_one(0, "rrb0");
    issue_one(3, "rrb3");

    // Backpressure and overflow
    do_reset();
    rdy = 1'b0; trig = 4'b0010;
    tick();
    trig = '0;
    chk("bp_pending", 32'(pending), 32'h2);
    chk("bp_ovf_first", 32'(ovf), 32'd0);
    wait_valid("bp");
    chk("bp_id", 32'(id), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 2) trig = 4'b0010;
      if (i == 5) en = 1'b0;
      tick();
      trig = '0;
      chk("bp_hold_valid", 32'(valid), 32'd1);
      chk("bp_hold_id", 32'(id), 32'd1);
    end
    en = 1'b1;
    chk("bp_ovf_set", 32'(ovf), 32'h2);
    chk("bp_pending_hold", 32'(pending), 32'h2);
    ovc = 4'b0010;
    tick();
    ovc = '0;
    chk("bp_ovf_clear", 32'(ovf), 32'd0);
    trig = 4'b0010; ovc = 4'b0010;
    tick();
    trig = '0; ovc = '0;
    chk("bp_ovf_set_wins", 32'(ovf), 32'h2);
    ovc = 4'b0010;
    tick();
    ovc = '0;
    chk("bp_ovf_clear2", 32'(ovf), 32'd0);
    rdy = 1'b1;
    tick();
    chk("bp_accept_valid", 32'(valid), 32'd0);
    chk("bp_accept_pending", 32'(pending), 32'd0);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("bp_done_idle", 32'(busy), 32'd0);
    $display("backpressure/overflow done");

    // Trigger in the same cycle as accept of the same source
    do_reset();
    rdy = 1'b0; trig = 4'b0001;
    tick();
    trig = '0;
    wait_valid("acc");
    chk("acc_id", 32'(id), 32'd0);
    rdy = 1'b1; trig = 4'b0001;
    tick();
    trig = '0;
    chk("acc_pending_kept", 32'(pending), 32'h1);
    chk("acc_no_ovf", 32'(ovf), 32'd0);
    chk("acc_valid_drop", 32'(valid), 32'd0);
    chk("acc_busy", 32'(busy), 32'd1);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("acc_idle_gap_busy", 32'(busy), 32'd0);
    chk("acc_idle_gap_valid", 32'(valid), 32'd0);
    tick();
    chk("acc_reissue_valid", 32'(valid), 32'd1);
    chk("acc_reissue_id", 32'(id), 32'd0);
    tick();
    chk("acc_reissue_pending", 32'(pending), 32'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("acc_done_idle", 32'(busy), 32'd0);
    $display("trigger at accept done");

    // Watchdog expiry, then done on the last allowed cycle
    do_reset();
    rdy = 1'b1; trig = 4'b0001;
    tick();
    trig = '0;
    tick();
    chk("to_valid", 32'(valid), 32'd1);
    tick();
    chk("to_wait_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("to_still_busy", 32'(busy), 32'd1);
      chk("to_not_yet", 32'(tmo), 32'd0);
    end
    tick();
    chk("to_expired", 32'(tmo), 32'd1);
    chk("to_idle", 32'(busy), 32'd0);
    toc = 1'b1;
    tick();
    toc = 1'b0;
    chk("to_clear", 32'(tmo), 32'd0);
    trig = 4'b0001;
    tick();
    trig = '0;
    tick();
    chk("to2_valid", 32'(valid), 32'd1);
    tick();
    repeat (7) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("to2_done_wins", 32'(tmo), 32'd0);
    chk("to2_idle", 32'(busy), 32'd0);
    $display("timeout done");

    // Enable gating and reset mid-operation
    do_reset();
    en = 1'b0; rdy = 1'b1; trig = 4'b0011;
    tick();
    trig = '0;
    repeat (3) begin
      tick();
      chk("en_no_start", 32'(valid), 32'd0);
    end
    chk("en_pending", 32'(pending), 32'h3);
    chk("en_not_busy", 32'(busy), 32'd0);
    en = 1'b1;
    tick();
    chk("en_valid", 32'(valid), 32'd1);
    chk("en_id", 32'(id), 32'd0);
    tick();
    chk("en_wait_busy", 32'(busy), 32'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_valid", 32'(valid), 32'd0);
    chk("mr_id", 32'(id), 32'd0);
    chk("mr_pending", 32'(pending), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_ovf", 32'(ovf), 32'd0);
    chk("mr_tmo", 32'(tmo), 32'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("mr_late_done_busy", 32'(busy), 32'd0);
    tick();
    chk("mr_late_done_valid", 32'(valid), 32'd0);
    $display("enable/reset done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
